// File: rtl/tdm_demux4_rx.sv
// Receive side of the 4-slot TDM link: tracks slot-0 sync alignment and presents
// each completed frame on a..d with a one-cycle frame_valid. Optional macro: TDM_PARITY_EN.
module tdm_demux4_rx #(
  parameter int WIDTH      = 4,
  parameter int MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
`ifdef TDM_PARITY_EN
  output logic [2:0]       slot,
  output logic             parity_err,
`else
  output logic [1:0]       slot,
`endif
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
);

`ifdef TDM_PARITY_EN
  localparam int NSLOT = 5;
  localparam int SW    = 3;
`else
  localparam int NSLOT = 4;
  localparam int SW    = 2;
`endif
  // Every slot except the completing one needs a shadow register.
  localparam int            NSH      = NSLOT - 1;
  localparam logic [SW-1:0] LAST     = SW'(NSLOT - 1);
  localparam logic [4:0]    MISS_LIM = 5'(MISS_LIMIT);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           r_state, w_state;
  logic [SW-1:0]    r_slot, w_slot;
  logic [3:0]       r_miss, w_miss;
  logic [4:0]       w_miss_inc;
  logic [WIDTH-1:0] r_sh [NSH];
  logic [WIDTH-1:0] w_sh [NSH];
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic [WIDTH-1:0] w_a, w_b, w_c, w_d;
  logic             r_fv, w_fv, r_serr, w_serr;
`ifdef TDM_PARITY_EN
  logic             r_perr, w_perr, w_par;
`endif

  always_comb begin
    w_miss_inc = {1'b0, r_miss} + 5'd1;
    w_state    = r_state;
    w_slot     = r_slot;
    w_miss     = r_miss;
    w_sh       = r_sh;
    w_a        = r_a;
    w_b        = r_b;
    w_c        = r_c;
    w_d        = r_d;
    w_fv       = 1'b0;
    w_serr     = 1'b0;
`ifdef TDM_PARITY_EN
    w_perr = 1'b0;
    w_par  = 1'b0;
    for (int k = 0; k < NSH; k++) w_par = w_par ^ (^r_sh[k]);
`endif
    if (din_valid) begin
      if (r_state == HUNT) begin
        if (sync) begin
          w_sh[0] = din;
          w_slot  = SW'(1);
          w_miss  = '0;
          w_state = LOCKED;
        end
      end else if (sync) begin
        // A marker anywhere but slot 0 drops the partial frame and realigns here.
        w_serr  = (r_slot != '0);
        w_sh[0] = din;
        w_slot  = SW'(1);
        w_miss  = '0;
      end else if (r_slot == '0) begin
        if (w_miss_inc < MISS_LIM) begin
          w_sh[0] = din;
          w_slot  = SW'(1);
          w_miss  = w_miss_inc[3:0];
        end else begin
          w_serr  = 1'b1;
          w_slot  = '0;
          w_miss  = '0;
          w_state = HUNT;
        end
      end else if (r_slot != LAST) begin
        for (int k = 1; k < NSH; k++)
          if (r_slot == SW'(k)) w_sh[k] = din;
        w_slot = r_slot + 1'b1;
      end else begin
        w_slot = '0;
`ifdef TDM_PARITY_EN
        if (w_par == din[0]) begin
          w_a  = r_sh[0];
          w_b  = r_sh[1];
          w_c  = r_sh[2];
          w_d  = r_sh[3];
          w_fv = 1'b1;
        end else begin
          w_perr = 1'b1;
        end
`else
        w_a  = r_sh[0];
        w_b  = r_sh[1];
        w_c  = r_sh[2];
        w_d  = din;
        w_fv = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
      r_slot  <= '0;
      r_miss  <= '0;
      for (int k = 0; k < NSH; k++) r_sh[k] <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_fv    <= 1'b0;
      r_serr  <= 1'b0;
`ifdef TDM_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_slot  <= w_slot;
      r_miss  <= w_miss;
      r_sh    <= w_sh;
      r_a     <= w_a;
      r_b     <= w_b;
      r_c     <= w_c;
      r_d     <= w_d;
      r_fv    <= w_fv;
      r_serr  <= w_serr;
`ifdef TDM_PARITY_EN
      r_perr  <= w_perr;
`endif
    end
  end

  assign a           = r_a;
  assign b           = r_b;
  assign c           = r_c;
  assign d           = r_d;
  assign slot        = r_slot;
  assign locked      = (r_state == LOCKED);
  assign frame_valid = r_fv;
  assign sync_err    = r_serr;
`ifdef TDM_PARITY_EN
  assign parity_err  = r_perr;
`endif

endmodule

// File: doc/tdm_demux4_rx.md
Name: tdm_demux4_rx

Overview:
Receive end of the 4-slot time-division link. The transmit end drives one shared line through a 4:1 mux, with slot select advancing 0..3.
This block tracks frame alignment from a sync marker on slot 0 and collects the four slot samples in shadow registers. It presents each completed frame on four parallel outputs, all updated together, with a one-cycle strobe.
It sits directly after the link line, ahead of per-channel consumers.

Parameters:
WIDTH, 4, bits per slot sample (1..32)
MISS_LIMIT, 2, consecutive slot-0 samples without sync before lock is dropped (1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  WIDTH  sample currently on the link line
din_valid  input  1  sample qualifier; nothing advances when low
sync  input  1  frame marker, meaningful only when din_valid=1; marks slot 0
a  output  WIDTH  slot-0 sample of last completed frame
b  output  WIDTH  slot-1 sample of last completed frame
c  output  WIDTH  slot-2 sample of last completed frame
d  output  WIDTH  slot-3 sample of last completed frame
slot  output  2  slot index assigned to the next accepted sample
locked  output  1  high while in LOCKED state
frame_valid  output  1  one-cycle pulse; a..d updated on this same edge
sync_err  output  1  one-cycle pulse on any alignment fault

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state=HUNT, slot=0, locked=0, frame_valid=0, sync_err=0, a..d=0, shadow regs=0, miss count=0.
  - Reset mid-frame discards the partial frame.
- Accepted sample: a rising edge with din_valid=1. With din_valid=0, all state and outputs hold, and frame_valid/sync_err return to 0.
- HUNT state:
  - Samples with sync=0 are discarded; slot stays 0.
  - Sample with sync=1: stored as slot 0, slot<=1, miss<=0, state<=LOCKED, locked<=1.
- LOCKED state, per accepted sample:
  - sync=1 and slot=0: stored in shadow[0], slot<=1, miss<=0.
  - sync=1 and slot!=0: misalignment. sync_err pulses, partial frame is discarded (no frame_valid). Sample is stored as slot 0, slot<=1, miss<=0; state stays LOCKED.
  - sync=0 and slot=0: missing marker, miss<=miss+1.
    - If miss+1 < MISS_LIMIT: sample accepted as slot 0, slot<=1.
    - Else: sync_err pulses, sample discarded, slot<=0, miss<=0, state<=HUNT, locked<=0.
  - sync=0 and slot 1..2: stored in shadow[slot], slot increments.
  - slot=3 (sync=0): completes the frame. On the same edge a<=shadow0, b<=shadow1, c<=shadow2, d<=din, frame_valid<=1, slot<=0 (wrap).
- Latency: a..d and frame_valid are visible one clock after the edge that accepts the slot-3 sample is launched, i.e. registered on that edge. Back-to-back frames give frame_valid every 4th cycle at full rate.
- a..d hold their last completed frame indefinitely, including across HUNT. Only rst clears them.
- frame_valid and sync_err are never high in the same cycle without the optional feature.

Optional Feature:
Macro TDM_PARITY_EN.
- Defined:
  - Frame is 5 slots, and slot widens to 3 bits (0..4).
  - Slot 4 carries even parity: its bit 0 is the XOR of all bits of slots 0..3; upper bits are ignored.
  - sync rules for slot 0 are unchanged. Misalignment applies for slot 1..4.
  - Slot 4 completes the frame.
    - Parity match: a..d<=shadow0..3 and frame_valid pulses.
    - Mismatch: a..d hold, no frame_valid, added output parity_err (1 bit, reset 0) pulses one cycle. Lock is not affected.
- Not defined: 4-slot frame as above, no parity_err port.

Test Plan:
1. Nominal frame: after rst, din_valid=1 each cycle, din=0x3(sync=1), 0x5, 0xA, 0xC -> after 4th edge a=0x3, b=0x5, c=0xA, d=0xC, frame_valid high exactly 1 cycle, locked=1, slot=0.
2. Hunt and reset: din=0x1, 0x2 with sync=0 -> locked=0, slot=0. Then sync frame 0x4 then 0x6, then rst for 1 cycle -> all outputs 0, HUNT. Then sync frame 0x9, 0x8, 0x7, 0x6 -> a..d=9,8,7,6, single frame_valid.
3. Gapped valid: nominal frame with din_valid=0 for 2 cycles between each slot -> same a..d as test 1. frame_valid only on the slot-3 edge; a..d unchanged during gaps.
4. Misalignment: frame 0x1(sync), 0x2, then 0x3 with sync=1 at slot 2, then 0x4, 0x5, 0x6 -> sync_err pulses once, no frame_valid for the partial frame. Then a..d=3,4,5,6 with frame_valid.
5. Lost lock, MISS_LIMIT=2: one sync frame, then a full frame with sync=0 -> delivered, frame_valid, miss=1. Next slot-0 sample without sync -> sync_err, locked=0, slot=0, a..d unchanged.
6. With TDM_PARITY_EN: frame 0x3, 0x5, 0xA, 0xC, parity=0 -> frame_valid, a..d updated. Same data with parity=1 -> parity_err pulse, no frame_valid, a..d hold, locked=1.
